boot_loader_ctrl: RTL and testbench

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

---
 rtl/boot_loader_ctrl.sv | 120 ++++++++++++
 tb/tb_boot_loader_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: loads host instruction words into instruction memory,
// then releases the core. It holds the core in reset again when halted.
// Optional feature: define BOOT_LOADER_CSUM_EN for an XOR checksum of loaded words.
module boot_loader_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start,
   input  logic [7:0]  load_len,
   input  logic        halt_req,
   input  logic        host_valid,
   input  logic [31:0] host_data,
   output logic        host_ready,
   output logic        imem_we,
   output logic [7:0]  imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_rst,
   output logic        sel,
   output logic [1:0]  state,
   output logic [31:0] csum
);

   localparam int unsigned LEN_W  = 8;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   state_t              r_state;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_count;
   logic                r_imem_we;
   logic [LEN_W-1:0]    r_imem_addr;
   logic [DATA_W-1:0]   r_imem_wdata;
   logic                r_core_rst;
   logic                w_hs;
   logic                w_last;

   // Handshake only while loading; last word when count reaches len-1
   assign w_hs   = (r_state == ST_LOAD) && host_valid;
   assign w_last = (r_count == LEN_W'(r_len - LEN_W'(1)));

   // Controller FSM with registered write port and core reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_len        <= '0;
         r_count      <= '0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_core_rst   <= 1'b0;
      end else begin
         r_imem_we  <= 1'b0;
         r_core_rst <= (r_state == ST_RUN);
         case (r_state)
            ST_IDLE: begin
               if (load_start && (load_len != '0)) begin
                  r_len   <= load_len;
                  r_count <= '0;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_hs) begin
                  r_imem_we    <= 1'b1;
                  r_imem_addr  <= r_count;
                  r_imem_wdata <= host_data;
                  r_count      <= LEN_W'(r_count + LEN_W'(1));
               end
               // Abort takes priority over completion; the in-flight word is still written
               if (halt_req) begin
                  r_state <= ST_IDLE;
               end else if (w_hs && w_last) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (halt_req) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef BOOT_LOADER_CSUM_EN
   logic [DATA_W-1:0] r_csum;

   // Running XOR of accepted words, cleared when a load is accepted
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_csum <= '0;
      end else if ((r_state == ST_IDLE) && load_start && (load_len != '0)) begin
         r_csum <= '0;
      end else if (w_hs) begin
         r_csum <= r_csum ^ host_data;
      end
   end

   assign csum = r_csum;
`else
   assign csum = '0;
`endif

   assign host_ready = (r_state == ST_LOAD);
   assign sel        = (r_state != ST_RUN);
   assign state      = r_state;
   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign core_rst   = r_core_rst;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed testbench for boot_loader_ctrl (works with or without BOOT_LOADER_CSUM_EN).
module tb_boot_loader_ctrl;

   logic        clk;
   logic        rst;
   logic        load_start;
   logic [7:0]  load_len;
   logic        halt_req;
   logic        host_valid;
   logic [31:0] host_data;
   logic        host_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_rst;
   logic        sel;
   logic [1:0]  state;
   logic [31:0] csum;

   int checks   = 0;
   int failures = 0;

   boot_loader_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_len   (load_len),
      .halt_req   (halt_req),
      .host_valid (host_valid),
      .host_data  (host_data),
      .host_ready (host_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .sel        (sel),
      .state      (state),
      .csum       (csum)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_csum(input string tag, input logic [31:0] exp_en);
`ifdef BOOT_LOADER_CSUM_EN
      chk(tag, csum, exp_en);
`else
      chk(tag, csum, 32'h0);
`endif
   endtask

   initial begin
      rst = 1'b0; load_start = 1'b0; load_len = 8'd0; halt_req = 1'b0;
      host_valid = 1'b0; host_data = 32'h0;

      // Reset for 3 cycles
      tick(); tick(); tick();
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_core_rst", 32'(core_rst), 32'h0);
      chk("rst_sel", 32'(sel), 32'h1);
      chk("rst_host_ready", 32'(host_ready), 32'h0);
      chk("rst_we", 32'(imem_we), 32'h0);
      chk("rst_addr", 32'(imem_addr), 32'h0);
      chk("rst_wdata", imem_wdata, 32'h0);
      chk_csum("rst_csum", 32'h0);
      rst = 1'b1;
      tick();
      chk("post_rst_state", 32'(state), 32'h0);

      // Zero length load and halt in IDLE are ignored
      load_start = 1'b1; load_len = 8'd0; halt_req = 1'b1;
      tick();
      load_start = 1'b0; halt_req = 1'b0;
      chk("zero_state", 32'(state), 32'h0);
      chk("zero_ready", 32'(host_ready), 32'h0);
      tick();
      chk("zero_state2", 32'(state), 32'h0);

      // Normal load of 3 words
      load_start = 1'b1; load_len = 8'd3;
      tick();
      load_start = 1'b0;
      chk("nl_state_load", 32'(state), 32'h1);
      chk("nl_ready", 32'(host_ready), 32'h1);
      chk("nl_sel_load", 32'(sel), 32'h1);
      host_valid = 1'b1; host_data = 32'h00000013;
      tick();
      chk("nl_we0", 32'(imem_we), 32'h1);
      chk("nl_addr0", 32'(imem_addr), 32'h0);
      chk("nl_data0", imem_wdata, 32'h00000013);
      host_data = 32'h00100093;
      tick();
      chk("nl_we1", 32'(imem_we), 32'h1);
      chk("nl_addr1", 32'(imem_addr), 32'h1);
      chk("nl_data1", imem_wdata, 32'h00100093);
      chk("nl_state_mid", 32'(state), 32'h1);
      host_data = 32'h00208113;
      tick();
      host_valid = 1'b0;
      chk("nl_we2", 32'(imem_we), 32'h1);
      chk("nl_addr2", 32'(imem_addr), 32'h2);
      chk("nl_data2", imem_wdata, 32'h00208113);
      chk("nl_state_run", 32'(state), 32'h2);
      chk("nl_core_rst_early", 32'(core_rst), 32'h0);
      chk("nl_sel_run", 32'(sel), 32'h0);
      chk("nl_ready_run", 32'(host_ready), 32'h0);
      tick();
      chk("nl_we_off", 32'(imem_we), 32'h0);
      chk("nl_core_rst", 32'(core_rst), 32'h1);
      chk("nl_addr_hold", 32'(imem_addr), 32'h2);
      chk("nl_data_hold", imem_wdata, 32'h00208113);
      chk_csum("nl_csum", 32'h00308193);

      // Halt and start together in RUN: halt wins
      halt_req = 1'b1; load_start = 1'b1; load_len = 8'd5;
      tick();
      halt_req = 1'b0; load_start = 1'b0;
      chk("hr_state", 32'(state), 32'h0);
      chk("hr_core_rst_lag", 32'(core_rst), 32'h1);
      tick();
      chk("hr_state2", 32'(state), 32'h0);
      chk("hr_core_rst", 32'(core_rst), 32'h0);
      chk("hr_sel", 32'(sel), 32'h1);
      chk_csum("hr_csum_hold", 32'h00308193);

      // Backpressure: valid pattern 1,0,0,1 with length 2
      load_start = 1'b1; load_len = 8'd2;
      tick();
      load_start = 1'b0;
      chk("bp_state", 32'(state), 32'h1);
      chk_csum("bp_csum_clr", 32'h0);
      host_valid = 1'b1; host_data = 32'hA5A5_0001;
      tick();
      chk("bp_we0", 32'(imem_we), 32'h1);
      chk("bp_addr0", 32'(imem_addr), 32'h0);
      host_valid = 1'b0; host_data = 32'hDEAD_BEEF;
      tick();
      chk("bp_idle_we1", 32'(imem_we), 32'h0);
      chk("bp_idle_addr", 32'(imem_addr), 32'h0);
      tick();
      chk("bp_idle_we2", 32'(imem_we), 32'h0);
      chk("bp_state_wait", 32'(state), 32'h1);
      host_valid = 1'b1; host_data = 32'h5A5A_0002;
      tick();
      host_valid = 1'b0;
      chk("bp_we1", 32'(imem_we), 32'h1);
      chk("bp_addr1", 32'(imem_addr), 32'h1);
      chk("bp_data1", imem_wdata, 32'h5A5A_0002);
      chk("bp_state_run", 32'(state), 32'h2);
      tick();
      chk("bp_we_off", 32'(imem_we), 32'h0);
      chk_csum("bp_csum", 32'hFFFF_0003);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      tick();
      chk("bp_back_idle", 32'(state), 32'h0);

      // Abort: length 4, halt during the 2nd handshake
      load_start = 1'b1; load_len = 8'd4;
      tick();
      load_start = 1'b0;
      host_valid = 1'b1; host_data = 32'h1111_1111;
      tick();
      chk("ab_we0", 32'(imem_we), 32'h1);
      chk("ab_addr0", 32'(imem_addr), 32'h0);
      host_data = 32'h2222_2222; halt_req = 1'b1;
      tick();
      host_valid = 1'b0; halt_req = 1'b0;
      chk("ab_we1", 32'(imem_we), 32'h1);
      chk("ab_addr1", 32'(imem_addr), 32'h1);
      chk("ab_data1", imem_wdata, 32'h2222_2222);
      chk("ab_state", 32'(state), 32'h0);
      chk("ab_ready", 32'(host_ready), 32'h0);
      tick();
      chk("ab_we_off", 32'(imem_we), 32'h0);
      chk("ab_core_rst", 32'(core_rst), 32'h0);
      chk_csum("ab_csum", 32'h3333_3333);

      // Reset mid-load: no further write
      load_start = 1'b1; load_len = 8'd2;
      tick();
      load_start = 1'b0;
      host_valid = 1'b1; host_data = 32'h7777_0000;
      rst = 1'b0;
      tick();
      chk("mr_we", 32'(imem_we), 32'h0);
      chk("mr_state", 32'(state), 32'h0);
      chk("mr_addr", 32'(imem_addr), 32'h0);
      chk_csum("mr_csum", 32'h0);
      host_valid = 1'b0; rst = 1'b1;
      tick();
      chk("mr_state2", 32'(state), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
